// File: rtl/rv32_pkg.sv
// Shared RV32I encodings, decode enums and immediate extraction for the
// verification core.
package rv32_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } aluOp_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} immFmt_t;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wbSel_t;

  // Opcode bits are never part of an immediate, so only [31:7] is passed in.
  function automatic logic [31:0] immGen(input logic [31:7] ins, input immFmt_t fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = {{20{ins[31]}}, ins[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/rv32_regfile.sv
// 32x32 register file: one synchronous write port, three asynchronous read
// ports, x0 always reads zero.
module rv32_regfile
  import rv32_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  input  logic [4:0]  raddr3_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  output logic [31:0] rdata3_o
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : regs_q[raddr2_i];
  assign rdata3_o = (raddr3_i == 5'd0) ? 32'd0 : regs_q[raddr3_i];

endmodule

// File: rtl/rv32_cpu_top_verify.sv
// Single-cycle RV32I core with external instruction fetch, internal data memory
// and a debug register read port. Define CPU_SUBWORD_MEM_EN for byte/half access.
module rv32_cpu_top_verify
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra3,
  output logic [31:0] rd3,
  input  logic [31:0] imem_out,
  output logic [31:0] imem_addr
);

  localparam int IDX_W = $clog2(DMEM_WORDS);

  logic [31:0] pc_q, pc_d;
  logic [31:0] dmem_q [DMEM_WORDS];

  logic [6:0]  opcode, funct7;
  logic [4:0]  rdAddr, rs1Addr, rs2Addr;
  logic [2:0]  funct3;

  logic        regWrite, memWrite, isBranch, isJal, isJalr;
  logic        aluSrcImm, aluSrcPc, branchTaken;
  logic        loadFunct3Ok, storeFunct3Ok;
  aluOp_t      aluOp;
  immFmt_t     immFmt;
  wbSel_t      wbSel;

  logic [31:0] imm, rs1Data, rs2Data, aluA, aluB, aluResult;
  logic [31:0] pcPlus4, memWord, loadData, storeData, rdData;
  logic [3:0]  storeBe;
  logic [IDX_W-1:0] memIdx;

  assign opcode  = imem_out[6:0];
  assign rdAddr  = imem_out[11:7];
  assign funct3  = imem_out[14:12];
  assign rs1Addr = imem_out[19:15];
  assign rs2Addr = imem_out[24:20];
  assign funct7  = imem_out[31:25];

  // Anything not decoded below leaves every enable low and so retires as a NOP.
  always_comb begin
    regWrite  = 1'b0;
    memWrite  = 1'b0;
    isBranch  = 1'b0;
    isJal     = 1'b0;
    isJalr    = 1'b0;
    aluSrcImm = 1'b0;
    aluSrcPc  = 1'b0;
    aluOp     = ALU_ADD;
    immFmt    = IMM_I;
    wbSel     = WB_ALU;
    case (opcode)
      OPC_LUI: begin
        regWrite  = 1'b1;
        aluSrcImm = 1'b1;
        aluOp     = ALU_PASS_B;
        immFmt    = IMM_U;
      end
      OPC_AUIPC: begin
        regWrite  = 1'b1;
        aluSrcImm = 1'b1;
        aluSrcPc  = 1'b1;
        immFmt    = IMM_U;
      end
      OPC_JAL: begin
        regWrite = 1'b1;
        isJal    = 1'b1;
        immFmt   = IMM_J;
        wbSel    = WB_PC4;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          regWrite  = 1'b1;
          isJalr    = 1'b1;
          aluSrcImm = 1'b1;
          wbSel     = WB_PC4;
        end
      end
      OPC_BRANCH: begin
        immFmt   = IMM_B;
        isBranch = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OPC_LOAD: begin
        aluSrcImm = 1'b1;
        wbSel     = WB_MEM;
        regWrite  = loadFunct3Ok;
      end
      OPC_STORE: begin
        aluSrcImm = 1'b1;
        immFmt    = IMM_S;
        memWrite  = storeFunct3Ok;
      end
      OPC_OP_IMM: begin
        aluSrcImm = 1'b1;
        regWrite  = 1'b1;
        case (funct3)
          F3_SLT:  aluOp = ALU_SLT;
          F3_SLTU: aluOp = ALU_SLTU;
          F3_XOR:  aluOp = ALU_XOR;
          F3_OR:   aluOp = ALU_OR;
          F3_AND:  aluOp = ALU_AND;
          F3_SLL: begin
            aluOp    = ALU_SLL;
            regWrite = (funct7 == F7_BASE);
          end
          F3_SR: begin
            aluOp    = funct7[5] ? ALU_SRA : ALU_SRL;
            regWrite = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
          default: aluOp = ALU_ADD;
        endcase
      end
      OPC_OP: begin
        regWrite = (funct7 == F7_BASE) ||
                   ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SR)));
        case (funct3)
          F3_SLL:  aluOp = ALU_SLL;
          F3_SLT:  aluOp = ALU_SLT;
          F3_SLTU: aluOp = ALU_SLTU;
          F3_XOR:  aluOp = ALU_XOR;
          F3_OR:   aluOp = ALU_OR;
          F3_AND:  aluOp = ALU_AND;
          F3_SR:   aluOp = funct7[5] ? ALU_SRA : ALU_SRL;
          default: aluOp = funct7[5] ? ALU_SUB : ALU_ADD;
        endcase
      end
      OPC_MISC_MEM, OPC_SYSTEM: ;
      default: ;
    endcase
  end

  assign imm = immGen(imem_out[31:7], immFmt);

  rv32_regfile u_regfile (
    .clk_i    (clk),
    .rst_i    (rst),
    .we_i     (regWrite & ~rst),
    .waddr_i  (rdAddr),
    .wdata_i  (rdData),
    .raddr1_i (rs1Addr),
    .raddr2_i (rs2Addr),
    .raddr3_i (ra3),
    .rdata1_o (rs1Data),
    .rdata2_o (rs2Data),
    .rdata3_o (rd3)
  );

  assign aluA = aluSrcPc  ? pc_q : rs1Data;
  assign aluB = aluSrcImm ? imm  : rs2Data;

  always_comb begin
    case (aluOp)
      ALU_SUB:    aluResult = aluA - aluB;
      ALU_SLL:    aluResult = aluA << aluB[4:0];
      ALU_SLT:    aluResult = {31'b0, $signed(aluA) < $signed(aluB)};
      ALU_SLTU:   aluResult = {31'b0, aluA < aluB};
      ALU_XOR:    aluResult = aluA ^ aluB;
      ALU_SRL:    aluResult = aluA >> aluB[4:0];
      ALU_SRA:    aluResult = $signed(aluA) >>> aluB[4:0];
      ALU_OR:     aluResult = aluA | aluB;
      ALU_AND:    aluResult = aluA & aluB;
      ALU_PASS_B: aluResult = aluB;
      default:    aluResult = aluA + aluB;
    endcase
  end

  always_comb begin
    case (funct3)
      F3_BEQ:  branchTaken = (rs1Data == rs2Data);
      F3_BNE:  branchTaken = (rs1Data != rs2Data);
      F3_BLT:  branchTaken = ($signed(rs1Data) <  $signed(rs2Data));
      F3_BGE:  branchTaken = ($signed(rs1Data) >= $signed(rs2Data));
      F3_BLTU: branchTaken = (rs1Data <  rs2Data);
      F3_BGEU: branchTaken = (rs1Data >= rs2Data);
      default: branchTaken = 1'b0;
    endcase
    branchTaken = branchTaken && isBranch;
  end

  assign pcPlus4 = pc_q + 32'd4;

  always_comb begin
    if (isJal || branchTaken) begin
      pc_d = pc_q + imm;
    end else if (isJalr) begin
      pc_d = aluResult & ~32'd1;
    end else begin
      pc_d = pcPlus4;
    end
  end

  // Upper address bits alias onto the memory; the byte offset only picks lanes.
  assign memIdx  = aluResult[IDX_W+1:2];
  assign memWord = dmem_q[memIdx];

`ifdef CPU_SUBWORD_MEM_EN
  logic [31:0] laneWord;
  logic [15:0] laneHalf;

  assign loadFunct3Ok  = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                         (funct3 == F3_LBU) || (funct3 == F3_LHU);
  assign storeFunct3Ok = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
  assign laneWord      = memWord >> {aluResult[1:0], 3'b000};
  assign laneHalf      = aluResult[1] ? memWord[31:16] : memWord[15:0];

  always_comb begin
    case (funct3)
      F3_LB:   loadData = {{24{laneWord[7]}}, laneWord[7:0]};
      F3_LBU:  loadData = {24'b0, laneWord[7:0]};
      F3_LH:   loadData = {{16{laneHalf[15]}}, laneHalf};
      F3_LHU:  loadData = {16'b0, laneHalf};
      default: loadData = memWord;
    endcase
    storeData = rs2Data;
    storeBe   = 4'b1111;
    case (funct3)
      F3_SB: begin
        storeData = {4{rs2Data[7:0]}};
        storeBe   = 4'b0001 << aluResult[1:0];
      end
      F3_SH: begin
        storeData = {2{rs2Data[15:0]}};
        storeBe   = aluResult[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end
`else
  assign loadFunct3Ok  = (funct3 == F3_LW);
  assign storeFunct3Ok = (funct3 == F3_SW);
  assign loadData      = memWord;
  assign storeData     = rs2Data;
  assign storeBe       = 4'b1111;
`endif

  always_comb begin
    case (wbSel)
      WB_MEM:  rdData = loadData;
      WB_PC4:  rdData = pcPlus4;
      default: rdData = aluResult;
    endcase
  end

  // Data memory is deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (!rst && memWrite) begin
      for (int b = 0; b < 4; b++) begin
        if (storeBe[b]) begin
          dmem_q[memIdx][8*b +: 8] <= storeData[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign imem_addr = pc_q;

endmodule

// File: tb/tb_rv32_cpu_top_verify.sv
// Directed and random instruction stream for rv32_cpu_top_verify, checked
// against an instruction-level architectural model.
module tb_rv32_cpu_top_verify;

  logic        clk;
  logic        rst;
  logic [4:0]  ra3;
  logic [31:0] rd3;
  logic [31:0] imem_out;
  logic [31:0] imem_addr;

  int checks = 0;
  int errors = 0;

  logic [31:0] mRegs [32];
  logic [31:0] mPc;
  logic [31:0] mMem [256];

  rv32_cpu_top_verify dut (
    .clk       (clk),
    .rst       (rst),
    .ra3       (ra3),
    .rd3       (rd3),
    .imem_out  (imem_out),
    .imem_addr (imem_addr)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Architectural effect of one instruction, straight from the ISA rules.
  task automatic modelStep(input logic [31:0] ins);
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b, immI, immS, immB, immU, immJ, res, addr, nxt, w;
    logic        wr, taken;
    rd = ins[11:7];
    f3 = ins[14:12];
    f7 = ins[31:25];
    a  = mRegs[ins[19:15]];
    b  = mRegs[ins[24:20]];
    immI = {{20{ins[31]}}, ins[31:20]};
    immS = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    immB = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    immU = {ins[31:12], 12'b0};
    immJ = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    nxt = mPc + 32'd4;
    wr = 1'b0;
    res = 32'd0;
    taken = 1'b0;
    case (ins[6:0])
      7'h37: begin res = immU; wr = 1'b1; end
      7'h17: begin res = mPc + immU; wr = 1'b1; end
      7'h6f: begin res = mPc + 32'd4; wr = 1'b1; nxt = mPc + immJ; end
      7'h67: if (f3 == 3'd0) begin res = mPc + 32'd4; wr = 1'b1; nxt = (a + immI) & ~32'd1; end
      7'h63: begin
        case (f3)
          3'd0: taken = (a == b);
          3'd1: taken = (a != b);
          3'd4: taken = ($signed(a) < $signed(b));
          3'd5: taken = !($signed(a) < $signed(b));
          3'd6: taken = (a < b);
          3'd7: taken = !(a < b);
          default: taken = 1'b0;
        endcase
        if (taken) nxt = mPc + immB;
      end
      7'h13: begin
        wr = 1'b1;
        case (f3)
          3'd0: res = a + immI;
          3'd2: res = ($signed(a) < $signed(immI)) ? 32'd1 : 32'd0;
          3'd3: res = (a < immI) ? 32'd1 : 32'd0;
          3'd4: res = a ^ immI;
          3'd6: res = a | immI;
          3'd7: res = a & immI;
          3'd1: begin res = a << immI[4:0]; wr = (f7 == 7'h00); end
          default: begin
            res = (f7 == 7'h20) ? 32'($signed(a) >>> immI[4:0]) : (a >> immI[4:0]);
            wr = (f7 == 7'h00) || (f7 == 7'h20);
          end
        endcase
      end
      7'h33: begin
        wr = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
        case (f3)
          3'd0: res = (f7 == 7'h20) ? a - b : a + b;
          3'd1: res = a << b[4:0];
          3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: res = (a < b) ? 32'd1 : 32'd0;
          3'd4: res = a ^ b;
          3'd6: res = a | b;
          3'd7: res = a & b;
          default: res = (f7 == 7'h20) ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
        endcase
      end
      7'h03: begin
        addr = a + immI;
        w = mMem[addr[9:2]];
        if (f3 == 3'd2) begin res = w; wr = 1'b1; end
`ifdef CPU_SUBWORD_MEM_EN
        w = w >> (8 * addr[1:0]);
        if (f3 == 3'd0) begin res = {{24{w[7]}}, w[7:0]}; wr = 1'b1; end
        if (f3 == 3'd4) begin res = {24'd0, w[7:0]}; wr = 1'b1; end
        w = addr[1] ? {16'd0, mMem[addr[9:2]][31:16]} : {16'd0, mMem[addr[9:2]][15:0]};
        if (f3 == 3'd1) begin res = {{16{w[15]}}, w[15:0]}; wr = 1'b1; end
        if (f3 == 3'd5) begin res = {16'd0, w[15:0]}; wr = 1'b1; end
`endif
      end
      7'h23: begin
        addr = a + immS;
        if (f3 == 3'd2) mMem[addr[9:2]] = b;
`ifdef CPU_SUBWORD_MEM_EN
        if (f3 == 3'd0) mMem[addr[9:2]][8*addr[1:0] +: 8] = b[7:0];
        if (f3 == 3'd1) mMem[addr[9:2]][16*addr[1] +: 16] = b[15:0];
`endif
      end
      default: ;
    endcase
    if (wr && (rd != 5'd0)) mRegs[rd] = res;
    mPc = nxt;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
    mPc = 32'h0000_0000;
  endtask

  function automatic logic [31:0] genInstr();
    logic [31:0] r, f;
    logic [2:0]  f3;
    logic [11:0] im;
    r  = $urandom;
    f  = $urandom;
    f3 = f[14:12];
    case (f[3:0])
      4'd0:  return {r[31:12], f[11:7], 7'h37};
      4'd1:  return {r[31:12], f[11:7], 7'h17};
      4'd2:  return {r[31:12], f[11:7], 7'h6f};
      4'd3:  return {r[31:20], f[19:15], 3'b000, f[11:7], 7'h67};
      4'd4, 4'd5: return {r[31:25], f[24:20], f[19:15], f3, r[11:7], 7'h63};
      4'd6, 4'd7: begin
        im = r[31:20];
        if (f3 == 3'd1) im = {7'h00, r[24:20]};
        if (f3 == 3'd5) im = {(r[0] ? 7'h20 : 7'h00), r[24:20]};
        return {im, f[19:15], f3, f[11:7], 7'h13};
      end
      4'd8, 4'd9: return {((r[0] && ((f3 == 3'd0) || (f3 == 3'd5))) ? 7'h20 : 7'h00),
                          f[24:20], f[19:15], f3, f[11:7], 7'h33};
      4'd10, 4'd11: return {r[31:20], f[19:15], (r[1] ? 3'b010 : f3), f[11:7], 7'h03};
      4'd12, 4'd13: return {r[31:25], f[24:20], f[19:15], (r[1] ? 3'b010 : f3), r[11:7], 7'h23};
      4'd14: begin
        case (r[1:0])
          2'd0:    return 32'h0000_000f;
          2'd1:    return 32'h0000_0073;
          2'd2:    return 32'h0010_0073;
          default: return {r[31:7], 7'h7f};
        endcase
      end
      default: return {7'h00, f[24:20], f[19:15], f3, f[11:7], 7'h33};
    endcase
  endfunction

  task automatic applyStimulus(input logic [31:0] ins);
    imem_out = ins;
    modelStep(ins);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input logic [31:0] ins);
    rst = 1'b1;
    imem_out = ins;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkReg(input string tag, input logic [4:0] idx, input logic [31:0] expected);
    ra3 = idx;
    #1;
    checkOutput(tag, rd3, expected);
  endtask

  initial begin
    logic [31:0] ins, r;
    logic [9:0]  off;
    rst = 1'b1;
    ra3 = 5'd0;
    imem_out = 32'h0000_0013;
    for (int i = 0; i < 256; i++) mMem[i] = 32'd0;

    doReset(32'h0000_0013);
    doReset(32'h0000_0013);
    checkOutput("reset_pc", imem_addr, 32'h0000_0000);
    checkReg("reset_x1", 5'd1, 32'd0);

    applyStimulus(32'h186a_00b7);
    checkReg("lui_x1", 5'd1, 32'h186a_0000);
    checkOutput("lui_pc", imem_addr, 32'd4);
    applyStimulus(32'hffc1_8137);
    checkReg("lui_neg_x2", 5'd2, 32'hffc1_8000);
    applyStimulus(32'hfff0_0193);
    applyStimulus(32'h0031_8233);
    checkReg("addi_x3", 5'd3, 32'hffff_ffff);
    checkReg("add_x4", 5'd4, 32'hffff_fffe);
    applyStimulus(32'h0030_2023);
    applyStimulus(32'h0000_2303);
    checkReg("lw_x6", 5'd6, 32'hffff_ffff);
    checkReg("x0_zero", 5'd0, 32'd0);
    checkOutput("seq_pc", imem_addr, 32'd24);

    doReset(32'h0000_0013);
    applyStimulus(32'h0080_02ef);
    checkOutput("jal_pc", imem_addr, 32'd8);
    checkReg("jal_link_x5", 5'd5, 32'd4);

    for (int i = 0; i < 256; i++) begin
      r = $urandom;
      off = i[9:0];
      applyStimulus({r[31:12], 5'd7, 7'h37});
      applyStimulus({r[11:0], 5'd7, 3'b000, 5'd7, 7'h13});
      applyStimulus({3'b000, off[9:6], 5'd7, 5'd0, 3'b010, off[5:3], off[2:0], 2'b00, 7'h23});
    end
    checkReg("init_x7", 5'd7, mRegs[7]);

    for (int n = 0; n < 600; n++) begin
      ins = genInstr();
      applyStimulus(ins);
      r = $urandom;
      checkOutput("rand_pc", imem_addr, mPc);
      checkReg("rand_rd", ins[11:7], mRegs[ins[11:7]]);
      checkReg("rand_reg", r[4:0], mRegs[r[4:0]]);
    end
    for (int i = 0; i < 32; i++) begin
      checkReg("final_reg", 5'(i), mRegs[i]);
    end

    doReset({12'd5, 5'd9, 3'b000, 5'd9, 7'h13});
    checkOutput("midreset_pc", imem_addr, 32'h0000_0000);
    for (int i = 0; i < 32; i++) begin
      checkReg("midreset_reg", 5'(i), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_cpu_top_verify.md
Name: rv32_cpu_top_verify

Overview:
- Single-cycle RV32I integer core wrapper used for per-instruction verification.
- Instruction memory is external: the core drives the fetch address and receives the instruction word combinationally in the same cycle.
- A third, verification-only asynchronous register-file read port exposes architectural register state.
- Data memory is internal.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DMEM_WORDS, 256, depth of the internal 32-bit data memory in words.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- ra3  in  5  verification read address into the register file.
- rd3  out  32  combinational read data for ra3; 0 when ra3==0.
- imem_out  in  32  instruction word at imem_addr; valid in the same cycle.
- imem_addr  out  32  byte address of the current instruction (= PC, combinational from the PC register).

Behaviour:
- Single-cycle execution, one instruction per clock:
  - decode imem_out combinationally;
  - at the rising edge, write rd (if any), perform any store, and update PC.
  - No stalls, no handshake.
- Reset (rst high at a rising edge):
  - PC <= RESET_PC, so imem_addr = RESET_PC after that edge.
  - x1..x31 <= 0.
  - No register write or store occurs on that edge.
  - Data memory is not cleared.
- Reset asserted mid-program has the same effect and overrides the current instruction.
- Register file:
  - 32x32; x0 is hardwired to 0 and writes to it are discarded.
  - Reads (rs1, rs2, ra3) are asynchronous.
  - A write becomes visible on rd3 immediately after the edge that performs it.
- Supported instructions (RV32I):
  - LUI: rd = {imm[31:12], 12'b0}.
  - AUIPC: rd = PC + U-imm.
  - JAL, JALR: rd = PC+4; JALR target has bit 0 cleared.
  - Branches: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
  - Memory: LW, SW.
- Arithmetic is mod 2^32 with no overflow flag. Shift amount is the low 5 bits of the operand. Immediates are sign-extended per the RV32I formats.
- PC update:
  - Taken branch or JAL: PC + imm.
  - JALR: (rs1 + imm) & ~1.
  - Otherwise: PC + 4.
  - PC wraps at 2^32. Misaligned targets are not trapped and are fetched as given.
- Data memory:
  - Word index = addr[log2(DMEM_WORDS)+1:2]; upper address bits are ignored (aliasing).
  - addr[1:0] is ignored for word accesses.
  - Store is written at the edge; load data is combinational.
- FENCE, ECALL, EBREAK and any unrecognised encoding execute as a NOP: PC+4, no state change.

Optional Feature:
- Macro: CPU_SUBWORD_MEM_EN.
- Defined: adds LB, LH, LBU, LHU, SB, SH.
  - Byte lane is selected by addr[1:0]; halfword lane by addr[1].
  - Byte/half stores use per-byte write enables.
  - Signed loads sign-extend; unsigned loads zero-extend.
- Undefined: those encodings are NOPs (PC+4, no register or memory write).

Decomposition:
- Package rv32_pkg:
  - opcode constants (LUI 7'b0110111, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM, SYSTEM);
  - funct3/funct7 constants;
  - ALU-op enum typedef;
  - immediate-format enum.
- One natural sub-module: rv32_regfile (32x32, one sync write port, three async read ports, x0 = 0). The ALU and decode stay in the top.

Test Plan:
- Reset, then imem_out=32'h186a_00b7 (LUI x1) for one clock; ra3=1 -> rd3=32'h186a_0000; imem_addr advances by 4.
- imem_out=32'hffc1_8137 (LUI x2); ra3=2 -> rd3=32'hffc1_8000 (negative upper immediate preserved).
- imem_out=32'hfff0_0193 (ADDI x3,x0,-1) then 32'h0031_8233 (ADD x4,x3,x3) -> x3=32'hffff_ffff, x4=32'hffff_fffe.
- imem_out=32'h0030_2023 (SW x3,0(x0)) then 32'h0000_2303 (LW x6,0(x0)) -> x6=32'hffff_ffff; ra3=0 -> rd3=0.
- After reset (imem_addr=0), imem_out=32'h0080_02ef (JAL x5,+8) -> imem_addr=8 next cycle, x5=4.
- Hold rst high across an edge with an ADDI presented -> no register write, imem_addr=RESET_PC, all registers read 0.
